// File: rtl/ir_json_pkg.sv
// Shared types and constants for the IR-event JSON formatter: FSM states, record templates, slot positions.
package ir_json_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUILD     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [7:0] LEN_BASE = 8'd24;
    localparam logic [7:0] LEN_REP  = 8'd32;

    localparam logic [4:0] ADDR_HI = 5'd9;
    localparam logic [4:0] ADDR_LO = 5'd10;
    localparam logic [4:0] CMD_HI  = 5'd20;
    localparam logic [4:0] CMD_LO  = 5'd21;
    localparam logic [4:0] REP_D   = 5'd30;

    // {"addr":"00","cmd":"00"} -- digit slots hold '0' and are overwritten while building
    localparam logic [7:0] TPL_BASE [24] = '{
        8'h7B, 8'h22, 8'h61, 8'h64, 8'h64, 8'h72, 8'h22, 8'h3A,
        8'h22, 8'h30, 8'h30, 8'h22, 8'h2C, 8'h22, 8'h63, 8'h6D,
        8'h64, 8'h22, 8'h3A, 8'h22, 8'h30, 8'h30, 8'h22, 8'h7D
    };

    // {"addr":"00","cmd":"00","rep":0}
    localparam logic [7:0] TPL_REP [32] = '{
        8'h7B, 8'h22, 8'h61, 8'h64, 8'h64, 8'h72, 8'h22, 8'h3A,
        8'h22, 8'h30, 8'h30, 8'h22, 8'h2C, 8'h22, 8'h63, 8'h6D,
        8'h64, 8'h22, 8'h3A, 8'h22, 8'h30, 8'h30, 8'h22, 8'h2C,
        8'h22, 8'h72, 8'h65, 8'h70, 8'h22, 8'h3A, 8'h30, 8'h7D
    };

endpackage

// File: rtl/ir_json_formatter_nibble_to_ascii.sv
// Combinational 4-bit nibble to ASCII hex digit; HEX_UPPER selects 'A'-'F' or 'a'-'f'.
module nibble_to_ascii #(
    parameter int HEX_UPPER = 1
) (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nib_i};
        end else if (HEX_UPPER != 0) begin
            ascii_o = 8'h37 + {4'h0, nib_i};
        end else begin
            ascii_o = 8'h57 + {4'h0, nib_i};
        end
    end

endmodule

// File: rtl/ir_json_formatter.sv
// Renders one decoded IR event into a fixed-layout JSON record for json_to_uart and holds it until done.
// Optional macro IR_REPEAT_EN appends a ,"rep":D field (32-byte record instead of 24).
module ir_json_formatter
    import ir_json_pkg::*;
#(
    parameter int MAX_LEN   = 32,
    parameter int HEX_UPPER = 1,
    parameter int DROP_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_valid,
    output logic              ir_ready,
    input  logic [7:0]        ir_addr,
    input  logic [7:0]        ir_cmd,
    input  logic              ir_repeat,
    output logic [7:0]        json_str [0:MAX_LEN-1],
    output logic [7:0]        json_len,
    output logic              start,
    input  logic              tx_done,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef IR_REPEAT_EN
    localparam logic [7:0] REC_LEN = LEN_REP;
    logic rep_q;
`else
    localparam logic [7:0] REC_LEN = LEN_BASE;
    logic unusedRepeat;
    assign unusedRepeat = ir_repeat;
`endif
    localparam logic [4:0] LAST_IDX = 5'(REC_LEN - 8'd1);

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [7:0]        addr_q, cmd_q;
    logic [7:0]        str_q [0:MAX_LEN-1];
    logic [7:0]        len_q;
    logic              start_q;
    logic              tx_done_q;
    logic [DROP_W-1:0] drop_q;

    logic [3:0] addrNib, cmdNib;
    logic [7:0] addrChr, cmdChr, curByte;

    nibble_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_addr_digit (.nib_i(addrNib), .ascii_o(addrChr));
    nibble_to_ascii #(.HEX_UPPER(HEX_UPPER)) u_cmd_digit  (.nib_i(cmdNib),  .ascii_o(cmdChr));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (ir_valid) begin
                    state_d = BUILD;
                    idx_d   = '0;
                end
            end
            BUILD: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == LAST_IDX) state_d = SEND;
            end
            SEND:      state_d = WAIT_DONE;
            // Only a fresh rising edge counts; a done level left over from the last record is ignored
            WAIT_DONE: if (tx_done && !tx_done_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        addrNib = (idx_q == ADDR_HI) ? addr_q[7:4] : addr_q[3:0];
        cmdNib  = (idx_q == CMD_HI)  ? cmd_q[7:4]  : cmd_q[3:0];
`ifdef IR_REPEAT_EN
        curByte = TPL_REP[idx_q];
`else
        curByte = TPL_BASE[idx_q];
`endif
        if (idx_q == ADDR_HI || idx_q == ADDR_LO) begin
            curByte = addrChr;
        end else if (idx_q == CMD_HI || idx_q == CMD_LO) begin
            curByte = cmdChr;
        end
`ifdef IR_REPEAT_EN
        else if (idx_q == REP_D) begin
            curByte = rep_q ? 8'h31 : 8'h30;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            addr_q    <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            start_q   <= 1'b0;
            tx_done_q <= 1'b0;
            drop_q    <= '0;
`ifdef IR_REPEAT_EN
            rep_q     <= 1'b0;
`endif
            for (int i = 0; i < MAX_LEN; i++) str_q[i] <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tx_done_q <= tx_done;
            start_q   <= (state_q == SEND);
            if (ir_valid && !ir_ready && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_W'(1);
            end
            if (state_q == IDLE && ir_valid) begin
                addr_q <= ir_addr;
                cmd_q  <= ir_cmd;
`ifdef IR_REPEAT_EN
                rep_q  <= ir_repeat;
`endif
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (i >= int'(REC_LEN)) str_q[i] <= 8'h00;
                end
            end
            // The buffer is read live by the transmitter, so it only moves while building
            if (state_q == BUILD) begin
                str_q[idx_q] <= curByte;
                if (idx_q == LAST_IDX) len_q <= REC_LEN;
            end
        end
    end

    assign ir_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign json_str = str_q;
    assign json_len = len_q;
    assign start    = start_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_ir_json_formatter.sv
// Scoreboard bench for ir_json_formatter: uppercase and lowercase instances share stimulus; records checked on start.
module tb_ir_json_formatter;

    localparam int MAX_LEN = 32;
`ifdef IR_REPEAT_EN
    localparam int REC_LEN = 32;
`else
    localparam int REC_LEN = 24;
`endif

    typedef struct packed {
        logic [255:0] upper;
        logic [255:0] lower;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       irValid, irRepeat, txDone;
    logic [7:0] irAddr, irCmd;
    logic       irReadyU, irReadyL, startU, startL, busyU, busyL;
    logic [7:0] jsonStrU [0:MAX_LEN-1];
    logic [7:0] jsonStrL [0:MAX_LEN-1];
    logic [7:0] jsonLenU, jsonLenL, dropU, dropL;
    logic [255:0] packU, packL;

    rec_t expQ[$];
    rec_t lastRec;
    rec_t popRec;
    int   nVectors = 0;
    int   nMiss = 0;
    int   expDrop = 0;

    always #5 clk = ~clk;

    ir_json_formatter #(.MAX_LEN(MAX_LEN), .HEX_UPPER(1), .DROP_W(8)) dutUpper (
        .clk(clk), .rst(rst), .ir_valid(irValid), .ir_ready(irReadyU), .ir_addr(irAddr),
        .ir_cmd(irCmd), .ir_repeat(irRepeat), .json_str(jsonStrU), .json_len(jsonLenU),
        .start(startU), .tx_done(txDone), .busy(busyU), .drop_cnt(dropU)
    );

    ir_json_formatter #(.MAX_LEN(MAX_LEN), .HEX_UPPER(0), .DROP_W(8)) dutLower (
        .clk(clk), .rst(rst), .ir_valid(irValid), .ir_ready(irReadyL), .ir_addr(irAddr),
        .ir_cmd(irCmd), .ir_repeat(irRepeat), .json_str(jsonStrL), .json_len(jsonLenL),
        .start(startL), .tx_done(txDone), .busy(busyL), .drop_cnt(dropL)
    );

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            packU[i*8 +: 8] = jsonStrU[i];
            packL[i*8 +: 8] = jsonStrL[i];
        end
    end

    function automatic logic [7:0] hexChar(input logic [3:0] n, input bit upper);
        if (n < 4'd10) return 8'h30 + 8'(n);
        return (upper ? 8'h41 : 8'h61) + 8'(n) - 8'd10;
    endfunction

    function automatic string hexByte(input logic [7:0] b, input bit upper);
        return $sformatf("%c%c", hexChar(b[7:4], upper), hexChar(b[3:0], upper));
    endfunction

    // Reference record built as a text string, byte 0 in the low bits
    function automatic logic [255:0] render(input logic [7:0] a, input logic [7:0] c,
                                            input logic r, input bit upper);
        string s;
        logic [255:0] v;
        v = '0;
        s = $sformatf("{\"addr\":\"%s\",\"cmd\":\"%s\"", hexByte(a, upper), hexByte(c, upper));
        if (REC_LEN == 32) s = $sformatf("%s,\"rep\":%0d}", s, r);
        else               s = $sformatf("%s}", s);
        for (int i = 0; i < s.len(); i++) v[i*8 +: 8] = s[i];
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiss++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] c, input logic r);
        rec_t e;
        irAddr   = a;
        irCmd    = c;
        irRepeat = r;
        irValid  = 1'b1;
        e.upper  = render(a, c, r, 1'b1);
        e.lower  = render(a, c, r, 1'b0);
        expQ.push_back(e);
    endtask

    // Called right after the accept edge; start must appear REC_LEN+1 edges later for one cycle
    task automatic waitStart(input string tag);
        int cyc;
        cyc = 0;
        while (!startU && cyc < 200) begin
            tick();
            cyc++;
        end
        checkOutput($sformatf("%s start latency", tag), 256'(cyc), 256'(REC_LEN + 1));
        tick();
        checkOutput($sformatf("%s start width", tag), 256'(startU), 256'(0));
    endtask

    task automatic sendRecord(input logic [7:0] a, input logic [7:0] c, input logic r, input string tag);
        applyStimulus(a, c, r);
        tick();
        irValid = 1'b0;
        checkOutput($sformatf("%s busy after accept", tag), 256'(busyU), 256'(1));
        waitStart(tag);
    endtask

    always @(negedge clk) begin
        if (startU) begin
            checkOutput("scoreboard has entry", 256'(expQ.size() > 0), 256'(1));
            if (expQ.size() > 0) begin
                popRec  = expQ.pop_front();
                lastRec = popRec;
                checkOutput("record upper", packU, popRec.upper);
                checkOutput("record lower", packL, popRec.lower);
                checkOutput("json_len", 256'(jsonLenU), 256'(REC_LEN));
                checkOutput("json_len lower", 256'(jsonLenL), 256'(REC_LEN));
                checkOutput("start lower", 256'(startL), 256'(1));
            end
        end
    end

    initial begin
        rst = 1'b1; irValid = 1'b0; irAddr = '0; irCmd = '0; irRepeat = 1'b0; txDone = 1'b0;
        tick();
        tick();
        checkOutput("reset json_str", packU, '0);
        checkOutput("reset json_len", 256'(jsonLenU), 256'(0));
        checkOutput("reset start", 256'(startU), 256'(0));
        checkOutput("reset ir_ready", 256'(irReadyU), 256'(1));
        checkOutput("reset busy", 256'(busyU), 256'(0));
        checkOutput("reset drop_cnt", 256'(dropU), 256'(0));
        rst = 1'b0;
        tick();

        $display("[TB] basic record uppercase");
        sendRecord(8'hA5, 8'h45, 1'b0, "t1");
        checkOutput("t1 byte9", 256'(jsonStrU[9]), 256'(8'h41));
        checkOutput("t1 byte10", 256'(jsonStrU[10]), 256'(8'h35));
        checkOutput("t1 byte20", 256'(jsonStrU[20]), 256'(8'h34));
        checkOutput("t1 byte21", 256'(jsonStrU[21]), 256'(8'h35));
        repeat (3) tick();
        checkOutput("t1 waiting busy", 256'(busyU), 256'(1));
        checkOutput("t1 frozen", packU, lastRec.upper);
        txDone = 1'b1;
        tick();
        checkOutput("t1 back to idle", 256'(busyU), 256'(0));
        checkOutput("t1 ready lower", 256'(irReadyL), 256'(1));

        $display("[TB] lowercase digits with stale tx_done held high");
        sendRecord(8'hFF, 8'h0B, 1'b1, "t2");
        checkOutput("t2 byte9", 256'(jsonStrL[9]), 256'(8'h66));
        checkOutput("t2 byte10", 256'(jsonStrL[10]), 256'(8'h66));
        checkOutput("t2 byte20", 256'(jsonStrL[20]), 256'(8'h30));
        checkOutput("t2 byte21", 256'(jsonStrL[21]), 256'(8'h62));
`ifdef IR_REPEAT_EN
        checkOutput("t2 byte23", 256'(jsonStrL[23]), 256'(8'h2C));
        checkOutput("t2 byte30", 256'(jsonStrL[30]), 256'(8'h31));
        checkOutput("t2 byte31", 256'(jsonStrL[31]), 256'(8'h7D));
`else
        checkOutput("t2 byte23", 256'(jsonStrL[23]), 256'(8'h7D));
        checkOutput("t2 tail zero", 256'(packL[255:192]), 256'(0));
`endif
        repeat (5) tick();
        checkOutput("t3 stale done ignored", 256'(busyU), 256'(1));
        txDone = 1'b0;
        tick();
        checkOutput("t3 done low still busy", 256'(busyU), 256'(1));
        txDone = 1'b1;
        tick();
        checkOutput("t3 fresh done idle", 256'(busyU), 256'(0));
        txDone = 1'b0;
        tick();

        $display("[TB] drops during WAIT_DONE");
        sendRecord(8'h3C, 8'hD2, 1'b0, "t4");
        irAddr = 8'h11; irCmd = 8'h22; irValid = 1'b1;
        repeat (3) begin
            tick();
            expDrop++;
        end
        irValid = 1'b0;
        checkOutput("t4 drop_cnt", 256'(dropU), 256'(expDrop));
        checkOutput("t4 ir_ready", 256'(irReadyU), 256'(0));
        checkOutput("t4 json_str unchanged", packU, lastRec.upper);

        $display("[TB] event coinciding with WAIT_DONE exit");
        applyStimulus(8'h5A, 8'h69, 1'b1);
        txDone = 1'b1;
        tick();
        expDrop++;
        checkOutput("t4s drop on exit", 256'(dropU), 256'(expDrop));
        checkOutput("t4s idle after exit", 256'(irReadyU), 256'(1));
        tick();
        irValid = 1'b0;
        checkOutput("t4s accepted next", 256'(busyU), 256'(1));
        waitStart("t4s");

        irAddr = 8'h99; irCmd = 8'h66; irValid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (expDrop < 255) expDrop++;
        end
        irValid = 1'b0;
        checkOutput("t4 drop saturate", 256'(dropU), 256'(expDrop));
        checkOutput("t4 drop saturate lower", 256'(dropL), 256'(255));
        txDone = 1'b0;
        tick();
        txDone = 1'b1;
        tick();
        checkOutput("t4 idle after sat", 256'(busyU), 256'(0));
        txDone = 1'b0;
        tick();

        $display("[TB] reset in the middle of BUILD");
        irAddr = 8'h77; irCmd = 8'h88; irRepeat = 1'b0; irValid = 1'b1;
        tick();
        irValid = 1'b0;
        repeat (10) tick();
        checkOutput("t5 building", 256'(busyU), 256'(1));
        rst = 1'b1;
        tick();
        checkOutput("t5 json_str cleared", packU, '0);
        checkOutput("t5 json_len cleared", 256'(jsonLenU), 256'(0));
        checkOutput("t5 busy cleared", 256'(busyU), 256'(0));
        checkOutput("t5 ready", 256'(irReadyU), 256'(1));
        checkOutput("t5 drop cleared", 256'(dropU), 256'(0));
        checkOutput("t5 busy lower", 256'(busyL), 256'(0));
        rst = 1'b0;
        expDrop = 0;
        tick();

`ifdef IR_REPEAT_EN
        $display("[TB] repeat flag field");
        sendRecord(8'h12, 8'h34, 1'b1, "t6a");
        checkOutput("t6 len", 256'(jsonLenU), 256'(32));
        checkOutput("t6 byte23", 256'(jsonStrU[23]), 256'(8'h2C));
        checkOutput("t6 byte30", 256'(jsonStrU[30]), 256'(8'h31));
        checkOutput("t6 byte31", 256'(jsonStrU[31]), 256'(8'h7D));
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        tick();
        sendRecord(8'h12, 8'h34, 1'b0, "t6b");
        checkOutput("t6 byte30 zero", 256'(jsonStrU[30]), 256'(8'h30));
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        tick();
`endif

        $display("[TB] random records");
        for (int k = 0; k < 4; k++) begin
            sendRecord(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", k));
            txDone = 1'b1;
            tick();
            checkOutput($sformatf("rand%0d idle", k), 256'(busyU), 256'(0));
            txDone = 1'b0;
            tick();
        end

        checkOutput("scoreboard drained", 256'(expQ.size()), 256'(0));
        checkOutput("final drop_cnt", 256'(dropU), 256'(expDrop));
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
